// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/release controller.
// Holds the opcode constants, the FSM state and hazard-kind enums, the
// counter widths, and the helper that classifies the hazard at entry.
package pipe_ctrl_pkg;

    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_LW  = 6'b100011;

    // Width of the wait counter shared by the load-use countdown and the
    // resolution timeout. Parameter ranges keep it from wrapping.
    localparam int CNT_W  = 8;
    // Width of the optional performance counters.
    localparam int PERF_W = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LU_WAIT   = 2'd1,
        CTRL_WAIT = 2'd2,
        RELEASE   = 2'd3
    } state_t;

    typedef enum logic {
        KIND_LU   = 1'b0,
        KIND_CTRL = 1'b1
    } kind_t;

    // Jumps and branches wait for EX to resolve them; every other stall
    // request is treated as a fixed-latency load-use hazard.
    function automatic kind_t classify_hazard(input logic [5:0] op);
        if (op == OP_J || op == OP_BEQ) begin
            return KIND_CTRL;
        end
        return KIND_LU;
    endfunction

endpackage

// File: rtl/sat_counter32.sv
// 32-bit event counter that saturates at all-ones instead of wrapping.
// Cleared by the synchronous active-high reset.
module sat_counter32
    import pipe_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    output logic [PERF_W-1:0] cnt
);

    logic [PERF_W-1:0] cnt_q;
    logic [PERF_W-1:0] cnt_d;

    // Next count: advance on inc unless already pinned at the maximum.
    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {PERF_W{1'b1}})) begin
            cnt_d = cnt_q + {{(PERF_W-1){1'b0}}, 1'b1};
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/stall_release_ctrl.sv
// Consumer side of the pipeline stall interface.
// Freezes PC and IF/ID and injects ID/EX bubbles while a hazard is pending,
// then emits a one-cycle release flag back to hazard detection.
// Optional build macro STALL_PERF_CNT_EN adds saturating cycle counters for
// load-use and control-transfer stalls (lu_stall_cnt, ctrl_stall_cnt).
//
// Handshake: stall_req is a level request sampled only in IDLE; the freeze
// applies combinationally in that same cycle. The request is acknowledged by
// flag, high for exactly one cycle (RELEASE); the requester must drop or
// re-evaluate its request after seeing flag. resolve_valid is a one-cycle
// strobe consumed only in CTRL_WAIT, with resolve_taken qualified by it.
module stall_release_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LW_STALL_CYCLES  = 1,
    parameter int MAX_RESOLVE_WAIT = 8
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_req,
    input  logic [5:0]  ifid_op,
    input  logic        resolve_valid,
    input  logic        resolve_taken,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        idex_bubble,
    output logic        ifid_flush,
    output logic        pc_redirect,
    output logic        flag,
    output logic        timeout_err
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [31:0] lu_stall_cnt,
    output logic [31:0] ctrl_stall_cnt
`endif
);

    // Load-use countdown starts here so LU_WAIT lasts LW_STALL_CYCLES cycles.
    localparam logic [CNT_W-1:0] LU_INIT = CNT_W'(LW_STALL_CYCLES - 1);
    // Last CTRL_WAIT count value; the next increment reaches the limit.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(MAX_RESOLVE_WAIT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    kind_t             kind_q, kind_d;
    logic              taken_q, taken_d;
    logic              timeout_q, timeout_d;
    kind_t             entry_kind;

    assign entry_kind = classify_hazard(ifid_op);

    // Next-state and output decode; reset forces the run-mode output values.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        kind_d      = kind_q;
        taken_d     = taken_q;
        timeout_d   = timeout_q;
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        pc_redirect = 1'b0;
        flag        = 1'b0;

        case (state_q)
            IDLE: begin
                // Mealy freeze so the request cycle itself is already stalled.
                pc_we       = !stall_req;
                ifid_we     = !stall_req;
                idex_bubble = stall_req;
                if (stall_req) begin
                    kind_d  = entry_kind;
                    taken_d = 1'b0;
                    if (entry_kind == KIND_CTRL) begin
                        state_d = CTRL_WAIT;
                        cnt_d   = '0;
                    end else begin
                        state_d = LU_WAIT;
                        cnt_d   = LU_INIT;
                    end
                end
            end
            LU_WAIT: begin
                pc_we       = 1'b0;
                ifid_we     = 1'b0;
                idex_bubble = 1'b1;
                if (cnt_q == '0) begin
                    state_d = RELEASE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            CTRL_WAIT: begin
                pc_we       = 1'b0;
                ifid_we     = 1'b0;
                idex_bubble = 1'b1;
                cnt_d       = cnt_q + 1'b1;
                // A resolution arriving on the timeout cycle still wins.
                if (resolve_valid) begin
                    taken_d = resolve_taken;
                    state_d = RELEASE;
                end else if (cnt_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    taken_d   = 1'b0;
                    state_d   = RELEASE;
                end
            end
            RELEASE: begin
                flag = 1'b1;
                if (kind_q == KIND_CTRL && taken_q) begin
                    pc_redirect = 1'b1;
                    ifid_flush  = 1'b1;
                end
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (reset) begin
            pc_we       = 1'b1;
            ifid_we     = 1'b1;
            idex_bubble = 1'b0;
            ifid_flush  = 1'b0;
            pc_redirect = 1'b0;
            flag        = 1'b0;
        end
    end

    // State, counter and latched-hazard registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            kind_q    <= KIND_LU;
            taken_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            kind_q    <= kind_d;
            taken_q   <= taken_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_err = timeout_q && !reset;

`ifdef STALL_PERF_CNT_EN
    logic lu_inc;
    logic ctrl_inc;

    // The IDLE request cycle is frozen too, so it counts toward its kind.
    assign lu_inc   = !reset && ((state_q == LU_WAIT) ||
                      (state_q == IDLE && stall_req && entry_kind == KIND_LU));
    assign ctrl_inc = !reset && ((state_q == CTRL_WAIT) ||
                      (state_q == IDLE && stall_req && entry_kind == KIND_CTRL));

    sat_counter32 u_lu_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (lu_inc),
        .cnt   (lu_stall_cnt)
    );

    sat_counter32 u_ctrl_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (ctrl_inc),
        .cnt   (ctrl_stall_cnt)
    );
`endif

endmodule
